// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port-RAM stream reader slice.
//   ADDR_W / DATA_W : default RAM address and data widths
//   DEPTH           : number of RAM entries addressed by ADDR_W
//   state_t         : reader FSM states
package dpram_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/dpram_stream_reader_if.sv
// Output stream bundle of the RAM reader (valid/ready handshake).
//   m_valid : beat present on m_data/m_last
//   m_ready : sink accepts the beat this cycle
//   m_data  : beat payload
//   m_last  : final beat of the transfer
interface dpram_stream_reader_if #(
  parameter int DATA_W = dpram_pkg::DATA_W
);

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/stream_fifo4.sv
// Four-entry synchronous FIFO with an occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data (ignored when full and not popping)
//   pop       : drop the head entry (ignored when empty)
//   head_data : current head entry (meaningful while count != 0)
//   count     : number of stored entries, 0..4
module stream_fifo4 #(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [2:0]   count
);

  logic [W-1:0] mem_r [4];
  logic [1:0]   wr_ptr_r;
  logic [1:0]   rd_ptr_r;
  logic [2:0]   count_r;
  logic         do_push_s;
  logic         do_pop_s;

  // Qualify requests so the storage can never over- or under-run.
  always_comb begin
    do_pop_s  = pop && (count_r != 3'd0);
    do_push_s = push && ((count_r != 3'd4) || do_pop_s);
  end

  // Data storage; no reset needed because count gates validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/dpram_stream_reader.sv
// Reads a run of consecutive RAM words and streams them out with valid/ready.
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle transfer request, honoured only while idle
//   base, len     : first address and beat count (len clamped to RAM depth)
//   rd_addr       : registered RAM read address
//   rd_data       : RAM read data, valid one cycle after rd_addr
//   busy          : transfer in progress
//   done          : one-cycle pulse after the last beat is accepted
//   strm          : output stream (master side)
module dpram_stream_reader #(
  parameter int ADDR_W = dpram_pkg::ADDR_W,
  parameter int DATA_W = dpram_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base,
  input  logic [ADDR_W:0]       len,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  dpram_stream_reader_if.master strm
);

  import dpram_pkg::*;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   rd_cnt_r;
  logic              busy_r;
  logic              done_r;
  // v1/v2 track a read through the RAM latency; l1/l2 carry its last flag.
  logic              v1_r, v2_r, l1_r, l2_r;

  logic [ADDR_W:0]   len_c_s;
  logic [ADDR_W:0]   rd_cnt_next_s;
  logic              last_rd_s;
  logic [3:0]        pending_s;
  logic              room_s;
  logic              fire_s;
  logic [2:0]        fifo_cnt_s;
  logic [DATA_W:0]   head_s;

  // Length clamp, issue throttling and handshake decode.
  always_comb begin
    if (len > LEN_MAX) begin
      len_c_s = LEN_MAX;
    end else begin
      len_c_s = len;
    end
    fire_s        = strm.m_valid && strm.m_ready;
    // Buffered plus in-flight words must stay within the 4 FIFO slots.
    pending_s     = {1'b0, fifo_cnt_s} + {3'b000, v1_r} + {3'b000, v2_r};
    room_s        = (pending_s < 4'd4);
    rd_cnt_next_s = rd_cnt_r + LEN_ONE;
    last_rd_s     = (rd_cnt_next_s == len_r);
  end

  // Transfer FSM: read issue, latency pipeline and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rd_addr_r <= {ADDR_W{1'b0}};
      len_r     <= {(ADDR_W+1){1'b0}};
      rd_cnt_r  <= {(ADDR_W+1){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      l1_r      <= 1'b0;
      l2_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      v1_r   <= 1'b0;
      l1_r   <= 1'b0;
      v2_r   <= v1_r;
      l2_r   <= l1_r;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (len_c_s == {(ADDR_W+1){1'b0}}) begin
              done_r <= 1'b1;
            end else begin
              // First read goes out with the start so data arrives early.
              len_r     <= len_c_s;
              rd_addr_r <= base;
              rd_cnt_r  <= LEN_ONE;
              v1_r      <= 1'b1;
              l1_r      <= (len_c_s == LEN_ONE);
              busy_r    <= 1'b1;
              state_r   <= (len_c_s == LEN_ONE) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (room_s) begin
            // Address wraps modulo the RAM depth by natural overflow.
            rd_addr_r <= rd_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            rd_cnt_r  <= rd_cnt_next_s;
            v1_r      <= 1'b1;
            l1_r      <= last_rd_s;
            if (last_rd_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (fire_s && strm.m_last) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  stream_fifo4 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (v2_r),
    .push_data ({l2_r, rd_data}),
    .pop       (fire_s),
    .head_data (head_s),
    .count     (fifo_cnt_s)
  );

  assign rd_addr      = rd_addr_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign strm.m_valid = (fifo_cnt_s != 3'd0);
  assign strm.m_data  = head_s[DATA_W-1:0];
  // Stale FIFO contents must not show a last flag while empty.
  assign strm.m_last  = strm.m_valid && head_s[DATA_W];

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader with a synchronous RAM model ram[i]=i.
module tb_dpram_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base;
  logic [10:0] len;
  logic [9:0]  rd_addr;
  logic [17:0] rd_data;
  logic        busy;
  logic        done;
  logic [17:0] ram [1024];
  int          n_cmp = 0;
  int          n_bad = 0;

  dpram_stream_reader_if #(.DATA_W(18)) sif ();

  dpram_stream_reader #(.ADDR_W(10), .DATA_W(18)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    (base),
    .len     (len),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .strm    (sif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= ram[rd_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_stream(input logic [9:0] b, input logic [10:0] l, input int exp_beats,
                            input bit rnd, input bit inject);
    int          cyc;
    int          beats;
    int          acc_cyc;
    bit          seen_v;
    bit          got_done;
    bit          stall;
    logic [17:0] hold_d;
    logic        hold_l;
    logic [9:0]  a;
    cyc = 0; beats = 0; acc_cyc = -10; seen_v = 0; got_done = 0; stall = 0;
    hold_d = 18'd0; hold_l = 1'b0;
    base = b; len = l; start = 1'b1; sif.m_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!got_done && cyc < exp_beats * 4 + 40) begin
      if (inject && cyc == 1) begin
        start = 1'b1; base = 10'h100; len = 11'd5;
      end else begin
        start = 1'b0;
      end
      if (cyc == 1) chk("busy_after_start", 32'(busy), 32'd1);
      sif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        chk("hold_valid", 32'(sif.m_valid), 32'd1);
        chk("hold_data", 32'(sif.m_data), 32'(hold_d));
        chk("hold_last", 32'(sif.m_last), 32'(hold_l));
      end
      if (sif.m_valid && !seen_v) begin
        seen_v = 1'b1;
        if (!rnd) chk("first_valid_cyc", 32'(cyc), 32'd3);
      end
      stall  = sif.m_valid && !sif.m_ready;
      hold_d = sif.m_data;
      hold_l = sif.m_last;
      if (sif.m_valid && sif.m_ready) begin
        a = b + 10'(beats);
        chk("beat_data", 32'(sif.m_data), 32'(a));
        chk("beat_last", 32'(sif.m_last), 32'(beats == exp_beats - 1));
        if (!rnd) chk("beat_cyc", 32'(cyc), 32'(3 + beats));
        beats++;
        acc_cyc = cyc;
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_cyc", 32'(cyc), 32'(acc_cyc + 1));
        chk("beat_count", 32'(beats), 32'(exp_beats));
      end else begin
        step();
        cyc++;
      end
    end
    start = 1'b0;
    sif.m_ready = 1'b1;
    chk("done_seen", 32'(got_done), 32'd1);
    step();
    chk("done_single", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    repeat (3) begin
      step();
      chk("idle_no_valid", 32'(sif.m_valid), 32'd0);
    end
  endtask

  initial begin
    int nb;
    for (int i = 0; i < 1024; i++) ram[i] = 18'(i);
    rst = 1'b1; start = 1'b0; base = 10'd0; len = 11'd0; sif.m_ready = 1'b1;
    repeat (2) step();
    chk("rst_valid", 32'(sif.m_valid), 32'd0);
    chk("rst_last", 32'(sif.m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;
    step();

    // Basic burst, ready always high.
    run_stream(10'h010, 11'd8, 8, 1'b0, 1'b0);
    // Address wrap 0x3FF -> 0x000.
    run_stream(10'h3FE, 11'd4, 4, 1'b0, 1'b0);
    // Random back-pressure.
    run_stream(10'h100, 11'd16, 16, 1'b1, 1'b0);
    // Single-beat transfer at the top address.
    run_stream(10'h3FF, 11'd1, 1, 1'b0, 1'b0);

    // Zero length: no beats, done the cycle after start.
    base = 10'h055; len = 11'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("len0_done", 32'(done), 32'd1);
    chk("len0_valid", 32'(sif.m_valid), 32'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    step();
    chk("len0_done_once", 32'(done), 32'd0);
    chk("len0_valid2", 32'(sif.m_valid), 32'd0);

    // Start while busy is ignored.
    run_stream(10'h020, 11'd3, 3, 1'b0, 1'b1);

    // Reset mid-transfer.
    base = 10'h040; len = 11'd10; start = 1'b1;
    step();
    start = 1'b0;
    nb = 0;
    for (int c = 0; c < 20; c++) begin
      if (sif.m_valid) nb++;
      if (nb == 3) break;
      step();
    end
    chk("abort_pre_beats", 32'(nb), 32'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", 32'(sif.m_valid), 32'd0);
    chk("abort_last", 32'(sif.m_last), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_addr", 32'(rd_addr), 32'd0);
    repeat (3) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_no_valid", 32'(sif.m_valid), 32'd0);
    end
    run_stream(10'h000, 11'd2, 2, 1'b0, 1'b0);

    // Over-long request clamps to the RAM depth.
    run_stream(10'h123, 11'd1100, 1024, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpram_stream_reader.md
DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the RAM address width (1024 entries).
REQ-002 Parameter DATA_W, default 18, SHALL set the RAM and stream data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL be a one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 base  input  ADDR_W  SHALL be the first RAM address, sampled with start.
REQ-007 len  input  ADDR_W+1  SHALL be the beat count, sampled with start.
REQ-008 rd_addr  output  ADDR_W  SHALL drive the RAM read-port address, from a register.
REQ-009 rd_data  input  DATA_W  SHALL be the RAM read-port data, valid one cycle after rd_addr.
REQ-010 m_valid  output  1  SHALL indicate m_data/m_last hold a valid beat.
REQ-011 m_ready  input  1  SHALL indicate the sink accepts the beat; a transfer occurs when m_valid && m_ready.
REQ-012 m_data  output  DATA_W  SHALL carry the beat payload.
REQ-013 m_last  output  1  SHALL mark the final beat of a transfer.
REQ-014 busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-015 done  output  1  SHALL pulse high for exactly one cycle when a transfer completes.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-017 IDLE->RUN SHALL occur on start with len!=0; start while busy SHALL be ignored.
REQ-018 Start with len==0 SHALL stay in IDLE, emit no beats and pulse done in the next cycle.
REQ-019 Len greater than 1024 SHALL be clamped to 1024.
REQ-020 Read n (0-based) SHALL use address (base+n) mod 1024; wrap from 1023 to 0 is silent.
REQ-021 RUN->DRAIN SHALL occur in the cycle the len-th read is issued; DRAIN->IDLE SHALL occur when the m_last beat is accepted, with done high in the following cycle.
REQ-022 Read data SHALL enter a 4-entry output FIFO one cycle after its address is on rd_addr.
REQ-023 A read SHALL be issued only if FIFO occupancy plus reads in flight (at most 2) stays at or below 4, so no data is lost when m_ready stalls.
REQ-024 With m_ready held high, the block SHALL emit one beat per cycle; the first m_valid SHALL appear 3 cycles after the start cycle.
REQ-025 m_data/m_last SHALL be held stable while m_valid && !m_ready.
REQ-026 Beats SHALL be delivered in address order with no duplication or loss.
REQ-027 rd_addr SHALL hold its last value when no read is issued.

Reset
REQ-028 On rst: state IDLE, busy=0, done=0, m_valid=0, m_last=0, rd_addr=0, FIFO empty, counters 0.
REQ-029 rst asserted mid-transfer SHALL abort immediately, discard buffered data and produce no done pulse.

Structure
REQ-030 ADDR_W, DATA_W, depth 1024 and the FSM state enum SHALL live in shared package dpram_pkg.
REQ-031 The output buffer SHALL be a sub-module stream_fifo4 (4-entry synchronous FIFO with count output).

Verification
REQ-032 RAM preloaded ram[i]=i; start, base=0x010, len=8, m_ready=1 -> data 0x010..0x017 on 8 consecutive cycles, first m_valid 3 cycles after start, m_last on 0x017, done 1 cycle after.
REQ-033 base=0x3FE, len=4 -> data from addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-034 len=16, m_ready toggling 1-0-0-1 random -> all 16 values in order, no loss, stable payload while stalled.
REQ-035 len=0 -> no m_valid, done pulses once the cycle after start; second start while busy with len=5 -> ignored.
REQ-036 rst asserted after 3 beats of a len=10 transfer -> all outputs at reset values next cycle, no done; new start base=0, len=2 -> values 0x000, 0x001.
REQ-037 len=1100 -> exactly 1024 beats, m_last on the 1024th.
